seg_digit_buffer: RTL and testbench

//  Holds the hex digits shown on the board's 7-segment bank. Accepts digit

---
 rtl/seg_digit_buffer_pkg.sv | 21 ++
 rtl/seg_digit_buffer_if.sv | 21 ++
 rtl/seg_digit_buffer_blink_prescaler.sv | 28 ++
 rtl/seg_digit_buffer.sv | 114 +++++++++++
 tb/tb_seg_digit_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg_digit_buffer_pkg.sv
// rtl/seg_digit_buffer_pkg.sv - shared opcodes, FSM states and constants for the digit buffer
// Contents:
//   OP_WRITE/OP_SHIFT/OP_CLEAR/OP_BLINK  2-bit command opcodes
//   state_t                              clear-sweep FSM states
//   SEG_OFF                              segment pattern for a dark display
package seg_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_BLINK = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } state_t;

  // Downstream top level drives this onto a display whose blank flag is set.
  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg_digit_buffer_if.sv
// rtl/seg_digit_buffer_if.sv - digit command handshake bundle
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave -> master  command can be accepted
//   cmd_op     master -> slave  opcode (seg_pkg OP_*)
//   cmd_idx    master -> slave  target digit
//   cmd_data   master -> slave  hex value, or blink enable in bit 0
interface seg_digit_buffer_if #(
  parameter int IDX_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [3:0]       cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_idx, output cmd_data,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_idx, input  cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/seg_digit_buffer_blink_prescaler.sv
// rtl/seg_digit_buffer_blink_prescaler.sv - free-running blink phase generator
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   phase  out  toggles every BLINK_DIV clk cycles
module blink_prescaler #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/seg_digit_buffer.sv
// rtl/seg_digit_buffer.sv - hex digit store for the 7-segment bank with blink and clear sweep
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cmd       slave command handshake (WRITE/SHIFT/CLEAR/BLINK)
//   digits_o  out  digit i on bits [4i+3:4i]
//   blank_o   out  1 = display i must be dark
module seg_digit_buffer
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int BLINK_DIV  = 25_000_000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_digit_buffer_if.slave       cmd,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o
);
  state_t                           state, state_n;
  logic [IDX_W-1:0]                 clr_cnt, clr_cnt_n;
  logic [NUM_DIGITS-1:0][3:0]       digit_q, digit_n;
  logic [NUM_DIGITS-1:0]            valid_q, valid_n;
  logic [NUM_DIGITS-1:0]            blink_q, blink_n;
  logic                             phase;
  logic                             accept;

  blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase)
  );

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign digits_o      = digit_q;

  // Index matches are done by comparison so an out-of-range cmd_idx simply
  // selects nothing when NUM_DIGITS is not a power of two.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    digit_n   = digit_q;
    valid_n   = valid_q;
    blink_n   = blink_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_WRITE: begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cmd.cmd_idx == IDX_W'(i)) begin
                  digit_n[i] = cmd.cmd_data;
                  valid_n[i] = 1'b1;
                end
              end
            end
            OP_SHIFT: begin
              digit_n = {digit_q[NUM_DIGITS-2:0], cmd.cmd_data};
              valid_n = {valid_q[NUM_DIGITS-2:0], 1'b1};
            end
            OP_BLINK: begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cmd.cmd_idx == IDX_W'(i)) blink_n[i] = cmd.cmd_data[0];
              end
            end
            OP_CLEAR: begin
              state_n   = ST_CLR;
              clr_cnt_n = '0;
            end
            default: ;
          endcase
        end
      end
      ST_CLR: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (clr_cnt == IDX_W'(i)) begin
            digit_n[i] = 4'h0;
            valid_n[i] = 1'b0;
            blink_n[i] = 1'b0;
          end
        end
        if (clr_cnt == IDX_W'(NUM_DIGITS - 1)) begin
          state_n   = ST_IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + IDX_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // blank_o is built from the next mask values so a command shows up on the
  // outputs one cycle after acceptance, same as digits_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      digit_q <= '0;
      valid_q <= '0;
      blink_q <= '0;
      blank_o <= '1;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      digit_q <= digit_n;
      valid_q <= valid_n;
      blink_q <= blink_n;
      blank_o <= ~valid_n | (blink_n & {NUM_DIGITS{phase}});
    end
  end
endmodule

// File: tb/tb_seg_digit_buffer.sv
// tb/tb_seg_digit_buffer.sv - directed self-checking bench for seg_digit_buffer
module tb_seg_digit_buffer;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_digit_buffer_if #(.IDX_W(3)) bus ();
  seg_digit_buffer_if #(.IDX_W(3)) bus6 ();

  logic [31:0] digits;
  logic [7:0]  blank;
  logic [23:0] digits6;
  logic [5:0]  blank6;

  seg_digit_buffer #(.NUM_DIGITS(8), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .digits_o(digits), .blank_o(blank)
  );

  seg_digit_buffer #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .cmd(bus6), .digits_o(digits6), .blank_o(blank6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  always @(posedge clk) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_data  = data;
    for (int t = 0; t < 40 && !acc; t++) begin
      acc = bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check_eq("accepted", acc, 1'b1);
  endtask

  task automatic send6(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data);
    bus6.cmd_valid = 1'b1;
    bus6.cmd_op    = op;
    bus6.cmd_idx   = idx;
    bus6.cmd_data  = data;
    check_eq("ready6", bus6.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus6.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] mask;
    logic [31:0] d_before;
    bus.cmd_valid = 0;  bus.cmd_op = 0;  bus.cmd_idx = 0;  bus.cmd_data = 0;
    bus6.cmd_valid = 0; bus6.cmd_op = 0; bus6.cmd_idx = 0; bus6.cmd_data = 0;

    // Reset state, held and just after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_blank", blank, 8'hFF);
    check_eq("rst_digits", digits, 32'h0);
    check_eq("rst_ready", bus.cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_blank", blank, 8'hFF);
    check_eq("rel_digits", digits, 32'h0);

    // WRITE idx3 = A
    send(OP_WRITE, 3'd3, 4'hA);
    check_eq("wr_digits", digits, 32'h0000A000);
    check_eq("wr_blank", blank, 8'hF7);

    // Back-to-back SHIFTs 1,2,3
    send(OP_SHIFT, 3'd0, 4'h1);
    check_eq("sh1_digits", digits, 32'h000A0001);
    check_eq("sh1_blank", blank, 8'hEE);
    send(OP_SHIFT, 3'd0, 4'h2);
    send(OP_SHIFT, 3'd0, 4'h3);
    check_eq("sh3_digits", digits, 32'h0A000123);
    check_eq("sh3_low", digits[11:0], 12'h123);
    check_eq("sh3_blank", blank, 8'hB8);
    for (int i = 4; i <= 8; i++) send(OP_SHIFT, 3'd0, 4'(i));
    check_eq("sh8_digits", digits, 32'h12345678);
    check_eq("sh8_blank", blank, 8'h00);
    for (int i = 9; i <= 12; i++) send(OP_SHIFT, 3'd0, 4'(i));
    check_eq("sh12_digits", digits, 32'h56789ABC);
    check_eq("sh12_blank", blank, 8'h00);

    // BLINK digit 0: blank_o[0] tracks the phase of the previous cycle
    send(OP_BLINK, 3'd0, 4'h1);
    for (int k = 0; k < 10; k++) begin
      check_eq("blink_blank", blank, {7'b0, 1'(((edge_n - 1) / 4) % 2)});
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("blink_digits", digits, 32'h56789ABC);
    send(OP_BLINK, 3'd0, 4'h0);
    check_eq("unblink_blank", blank, 8'h00);

    // CLEAR sweep with a WRITE held pending
    send(OP_CLEAR, 3'd0, 4'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_idx   = 3'd2;
    bus.cmd_data  = 4'h5;
    check_eq("clr_start_blank", blank, 8'h00);
    for (int k = 0; k < 8; k++) begin
      check_eq("clr_ready", bus.cmd_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      mask = (64'h1 << (k + 1)) - 64'h1;
      check_eq("clr_blank", blank, mask[7:0]);
      mask = (64'h1 << (4 * (k + 1))) - 64'h1;
      check_eq("clr_digits", digits, 32'h56789ABC & ~mask[31:0]);
    end
    check_eq("clr_done_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("post_clr_digits", digits, 32'h00000500);
    check_eq("post_clr_blank", blank, 8'hFB);

    // Reset in the middle of a CLEAR sweep
    send(OP_WRITE, 3'd6, 4'h9);
    send(OP_WRITE, 3'd7, 4'h3);
    check_eq("pre_clr_digits", digits, 32'h39000500);
    send(OP_CLEAR, 3'd0, 4'h0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    d_before = digits;
    check_eq("midclr_digits", d_before, 32'h39000000);
    check_eq("midclr_blank", blank, 8'h3F);
    rst_n = 1'b0;
    #1;
    check_eq("arst_blank", blank, 8'hFF);
    check_eq("arst_digits", digits, 32'h0);
    check_eq("arst_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rel2_blank", blank, 8'hFF);
    check_eq("rel2_ready", bus.cmd_ready, 1'b1);

    // Consecutive WRITEs to one index: last value wins
    send(OP_WRITE, 3'd7, 4'hE);
    send(OP_WRITE, 3'd4, 4'h1);
    send(OP_WRITE, 3'd4, 4'h2);
    check_eq("lastwin_digits", digits, 32'hE0020000);
    check_eq("lastwin_blank", blank, 8'h6F);

    // Out-of-range index on the six-digit build
    send6(OP_WRITE, 3'd7, 4'hF);
    check_eq("oor7_digits", digits6, 24'h0);
    check_eq("oor7_blank", blank6, 6'h3F);
    send6(OP_BLINK, 3'd6, 4'h1);
    send6(OP_WRITE, 3'd6, 4'hF);
    check_eq("oor6_digits", digits6, 24'h0);
    check_eq("oor6_blank", blank6, 6'h3F);
    send6(OP_WRITE, 3'd5, 4'h9);
    check_eq("d6_digits", digits6, 24'h900000);
    check_eq("d6_blank", blank6, 6'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
